// File: rtl/sblk_agen.sv
`default_nettype none
// ============================================================================
// Module      : sblk_agen
// Description : Address generator for a systolic convolution tile. Walks the
//               loop nest kw -> win -> ofm -> kh -> pass (innermost first) and
//               issues one operation per cycle: an activation read, a weight
//               read and, on the first kernel column, either a psum read or a
//               forced-zero cascade input. A PIPE_LAT-deep delay line returns
//               the psum write (with final-result flag) for every last kernel
//               column.
// Ports       : clk_h, rst (sync, active high), start, stall
//               cfg_kernel/stride/nwin/nofm/npass : job shape (each minus one)
//               busy, done                        : job status
//               act_rd_en/addr, w_rd_addr         : operand reads
//               psum_rd_en/addr, acc_zero         : accumulator source
//               psum_wr_en/addr, out_valid        : accumulator write-back
// Revision    : 1.0  initial release
// ============================================================================
module sblk_agen #(
    parameter int KMAX        = 8,
    parameter int WINMAX      = 32,
    parameter int OFMMAX      = 16,
    parameter int PASSMAX     = 16,
    parameter int ACTADDR_BIT = 6,
    parameter int WADDR_BIT   = 10,
    parameter int PBADDR_BIT  = 10,
    parameter int PIPE_LAT    = 4
) (
    input  logic                        clk_h,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stall,
    input  logic [$clog2(KMAX)-1:0]     cfg_kernel,
    input  logic [1:0]                  cfg_stride,
    input  logic [$clog2(WINMAX)-1:0]   cfg_nwin,
    input  logic [$clog2(OFMMAX)-1:0]   cfg_nofm,
    input  logic [$clog2(PASSMAX)-1:0]  cfg_npass,
    output logic                        busy,
    output logic                        done,
    output logic                        act_rd_en,
    output logic [ACTADDR_BIT-1:0]      act_rd_addr,
    output logic [WADDR_BIT-1:0]        w_rd_addr,
    output logic                        psum_rd_en,
    output logic [PBADDR_BIT-1:0]       psum_rd_addr,
    output logic                        acc_zero,
    output logic                        psum_wr_en,
    output logic [PBADDR_BIT-1:0]       psum_wr_addr,
    output logic                        out_valid
);

    localparam int c_KB = $clog2(KMAX);
    localparam int c_WB = $clog2(WINMAX);
    localparam int c_OB = $clog2(OFMMAX);
    localparam int c_PB = $clog2(PASSMAX);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    // Latched job configuration
    logic [c_KB-1:0] r_kernel;
    logic [1:0]      r_stride;
    logic [c_WB-1:0] r_nwin;
    logic [c_OB-1:0] r_nofm;
    logic [c_PB-1:0] r_npass;

    // Loop counters; they always point at the next operation to issue
    logic [c_KB-1:0] r_kw;
    logic [c_WB-1:0] r_win;
    logic [c_OB-1:0] r_ofm;
    logic [c_KB-1:0] r_kh;
    logic [c_PB-1:0] r_pass;

    // Registered issue outputs
    logic                   r_act_en;
    logic [ACTADDR_BIT-1:0] r_act_addr;
    logic [WADDR_BIT-1:0]   r_w_addr;
    logic                   r_prd_en;
    logic [PBADDR_BIT-1:0]  r_prd_addr;
    logic                   r_acc_zero;
    logic                   r_done;

    // Write-back delay line: stage 0 is aligned with the issue outputs,
    // stage PIPE_LAT drives the psum write port.
    logic [PIPE_LAT:0]      r_dv;
    logic [PIPE_LAT:0]      r_df;
    logic [PBADDR_BIT-1:0]  r_da [0:PIPE_LAT];

    // The very first issue happens on the start edge itself, before the
    // configuration registers are loaded, so the live inputs are used in IDLE.
    logic            w_idle;
    logic [c_KB-1:0] w_kernel;
    logic [1:0]      w_stride;
    logic [c_WB-1:0] w_nwin;
    logic [c_OB-1:0] w_nofm;
    logic [c_PB-1:0] w_npass;

    assign w_idle   = (r_state == c_S_IDLE);
    assign w_kernel = w_idle ? cfg_kernel : r_kernel;
    assign w_stride = w_idle ? cfg_stride : r_stride;
    assign w_nwin   = w_idle ? cfg_nwin   : r_nwin;
    assign w_nofm   = w_idle ? cfg_nofm   : r_nofm;
    assign w_npass  = w_idle ? cfg_npass  : r_npass;

    logic w_kw_wrap, w_win_wrap, w_ofm_wrap, w_kh_wrap, w_pass_wrap;
    logic w_last, w_first_acc, w_pend;
    logic w_issue, w_done_set;

    assign w_kw_wrap   = (r_kw   == w_kernel);
    assign w_win_wrap  = (r_win  == w_nwin);
    assign w_ofm_wrap  = (r_ofm  == w_nofm);
    assign w_kh_wrap   = (r_kh   == w_kernel);
    assign w_pass_wrap = (r_pass == w_npass);
    assign w_last      = w_kw_wrap & w_win_wrap & w_ofm_wrap & w_kh_wrap & w_pass_wrap;
    // First contribution to a psum location: nothing to read back yet
    assign w_first_acc = (r_kh == '0) && (r_pass == '0);
    // Any write still travelling behind the one at the output stage
    assign w_pend      = |r_dv[PIPE_LAT-1:0];

    // Address arithmetic, truncated to each port width
    logic [31:0]            w_k32;
    logic [ACTADDR_BIT-1:0] w_act_addr;
    logic [WADDR_BIT-1:0]   w_w_addr;
    logic [PBADDR_BIT-1:0]  w_pb_addr;

    assign w_k32      = 32'(w_kernel) + 32'd1;
    assign w_act_addr = ACTADDR_BIT'(32'(r_win) * (32'(w_stride) + 32'd1) + 32'(r_kw));
    assign w_w_addr   = WADDR_BIT'(32'(r_ofm) * w_k32 * w_k32 + 32'(r_kh) * w_k32 + 32'(r_kw));
    assign w_pb_addr  = PBADDR_BIT'(32'(r_ofm) * (32'(w_nwin) + 32'd1) + 32'(r_win));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_h) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else if (!stall) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_issue     = 1'b1;
                    // A single-operation job goes straight to draining
                    w_state_nxt = w_last ? c_S_DRAIN : c_S_RUN;
                end
            end
            c_S_RUN: begin
                w_issue = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                // The last issue is always a last-column write, so once it is
                // at the output with nothing behind it the job is complete.
                if (r_dv[PIPE_LAT] && !w_pend) begin
                    w_state_nxt = c_S_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, issue registers and write-back delay line
    // ------------------------------------------------------------------
    always_ff @(posedge clk_h) begin
        if (rst) begin
            r_kernel   <= '0;
            r_stride   <= '0;
            r_nwin     <= '0;
            r_nofm     <= '0;
            r_npass    <= '0;
            r_kw       <= '0;
            r_win      <= '0;
            r_ofm      <= '0;
            r_kh       <= '0;
            r_pass     <= '0;
            r_act_en   <= 1'b0;
            r_act_addr <= '0;
            r_w_addr   <= '0;
            r_prd_en   <= 1'b0;
            r_prd_addr <= '0;
            r_acc_zero <= 1'b0;
            r_done     <= 1'b0;
            r_dv       <= '0;
            r_df       <= '0;
            for (int i = 0; i <= PIPE_LAT; i++) begin
                r_da[i] <= '0;
            end
        end else if (!stall) begin
            r_done <= w_done_set;

            if (w_idle && start) begin
                r_kernel <= cfg_kernel;
                r_stride <= cfg_stride;
                r_nwin   <= cfg_nwin;
                r_nofm   <= cfg_nofm;
                r_npass  <= cfg_npass;
            end

            r_act_en   <= w_issue;
            r_prd_en   <= w_issue && (r_kw == '0) && !w_first_acc;
            r_acc_zero <= w_issue && (r_kw == '0) && w_first_acc;

            if (w_issue) begin
                r_act_addr <= w_act_addr;
                r_w_addr   <= w_w_addr;
                r_prd_addr <= w_pb_addr;

                // Nested advance; after the final issue every counter wraps
                // back to zero, ready for the next job.
                if (w_kw_wrap) begin
                    r_kw <= '0;
                    if (w_win_wrap) begin
                        r_win <= '0;
                        if (w_ofm_wrap) begin
                            r_ofm <= '0;
                            if (w_kh_wrap) begin
                                r_kh   <= '0;
                                r_pass <= w_pass_wrap ? '0 : r_pass + 1'b1;
                            end else begin
                                r_kh <= r_kh + 1'b1;
                            end
                        end else begin
                            r_ofm <= r_ofm + 1'b1;
                        end
                    end else begin
                        r_win <= r_win + 1'b1;
                    end
                end else begin
                    r_kw <= r_kw + 1'b1;
                end
            end

            r_dv[0] <= w_issue && w_kw_wrap;
            r_df[0] <= w_kh_wrap && w_pass_wrap;
            r_da[0] <= w_pb_addr;
            for (int i = 1; i <= PIPE_LAT; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_df[i] <= r_df[i-1];
                r_da[i] <= r_da[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes are masked while stalled; the underlying registers
    // are frozen, so each strobe re-emits once the stall is released.
    // ------------------------------------------------------------------
    assign busy         = (r_state != c_S_IDLE);
    assign done         = r_done & ~stall;
    assign act_rd_en    = r_act_en & ~stall;
    assign act_rd_addr  = r_act_addr;
    assign w_rd_addr    = r_w_addr;
    assign psum_rd_en   = r_prd_en & ~stall;
    assign psum_rd_addr = r_prd_addr;
    assign acc_zero     = r_acc_zero;
    assign psum_wr_en   = r_dv[PIPE_LAT] & ~stall;
    assign psum_wr_addr = r_da[PIPE_LAT];
    assign out_valid    = r_dv[PIPE_LAT] & r_df[PIPE_LAT] & ~stall;

endmodule
`default_nettype wire
